// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage. Owns the program counter, fetches
// from a variable-latency instruction memory, holds the fetched word for the
// decode stage until commit, then resolves the next PC for sequential flow,
// conditional branches, jal and jalr.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    input  logic [31:0] imm32,
    input  logic        commit,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } fetchState_e;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    fetchState_e state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        instValid_q;
    logic        fetchErr_q;

    logic [31:0] pc_d;
    logic [31:0] seqPc;
    logic [31:0] relTarget;
    logic [31:0] jalrTarget;
    logic        branchTaken;
    logic        targetMisaligned;

    assign seqPc      = pc_q + 32'd4;
    assign relTarget  = pc_q + imm32;
    assign jalrTarget = (rs1Data + imm32) & 32'hFFFF_FFFE;

    // Evaluate the branch condition selected by funct3 of the held instruction
    always_comb begin
        branchTaken = 1'b0;
        unique case (inst_q[14:12])
            3'b000:  branchTaken = (rs1Data == rs2Data);
            3'b001:  branchTaken = (rs1Data != rs2Data);
            3'b100:  branchTaken = ($signed(rs1Data) <  $signed(rs2Data));
            3'b101:  branchTaken = ($signed(rs1Data) >= $signed(rs2Data));
            3'b110:  branchTaken = (rs1Data <  rs2Data);
            3'b111:  branchTaken = (rs1Data >= rs2Data);
            default: branchTaken = 1'b0;
        endcase
    end

    // Resolve the next PC from the opcode of the held instruction
    always_comb begin
        pc_d = seqPc;
        unique case (inst_q[6:0])
            OP_BRANCH: pc_d = branchTaken ? relTarget : seqPc;
            OP_JAL:    pc_d = relTarget;
            OP_JALR:   pc_d = jalrTarget;
            default:   pc_d = seqPc;
        endcase
    end

    assign targetMisaligned = (pc_d[1:0] != 2'b00);

    // Fetch FSM: request, wait for data, hold until commit, then advance or trap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            instValid_q <= 1'b0;
            fetchErr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        inst_q      <= imem_rdata;
                        instValid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (commit) begin
                        pc_q        <= pc_d;
                        inst_q      <= NOP_INST;
                        instValid_q <= 1'b0;
                        if (targetMisaligned) begin
                            fetchErr_q <= 1'b1;
                            state_q    <= ST_ERROR;
                        end else begin
                            state_q    <= ST_FETCH;
                        end
                    end
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    state_q <= ST_ERROR;
                end
            endcase
        end
    end

    // The request is gated by reset so it stays low while the stage is held in reset
    assign imem_req   = (state_q == ST_FETCH) && !rst;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc_plus4   = seqPc;
    assign inst       = inst_q;
    assign inst_valid = instValid_q;
    assign fetch_err  = fetchErr_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit.
module tb_ifetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0010_8093;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] BNE  = 32'h0000_1063;
    localparam logic [31:0] BR10 = 32'h0000_2063;
    localparam logic [31:0] BLT  = 32'h0000_4063;
    localparam logic [31:0] BGE  = 32'h0000_5063;
    localparam logic [31:0] BLTU = 32'h0000_6063;
    localparam logic [31:0] BGEU = 32'h0000_7063;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] JALR = 32'h0000_0067;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] rs1Data = 32'h0;
    logic [31:0] rs2Data = 32'h0;
    logic [31:0] imm32 = 32'h0;
    logic        commit = 1'b0;
    logic        fetch_err;

    int nCompared = 0;
    int nMismatched = 0;

    ifetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .imm32(imm32),
        .commit(commit), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    // Minimal-latency fetch: leaves the DUT in HOLD with the given word
    task fetchWord(input logic [31:0] word);
        imem_ready = 1'b1;
        tick;
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = word;
        tick;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task commitWith(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        rs1Data = a;
        rs2Data = b;
        imm32 = im;
        commit = 1'b1;
        tick;
        commit = 1'b0;
    endtask

    task test_reset;
        rst = 1'b1;
        tick;
        tick;
        nCompared++; if (pc !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_pc got %h want %h", pc, 32'h0); end
        nCompared++; if (inst !== NOP) begin nMismatched++; $display("[TB] FAIL reset_inst got %h want %h", inst, NOP); end
        nCompared++; if (inst_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid got %b want 0", inst_valid); end
        nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req got %b want 0", imem_req); end
        nCompared++; if (fetch_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err got %b want 0", fetch_err); end
        rst = 1'b0;
        #1;
        nCompared++; if (imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL release_req got %b want 1", imem_req); end
        nCompared++; if (imem_addr !== 32'h0) begin nMismatched++; $display("[TB] FAIL release_addr got %h want 0", imem_addr); end
    endtask

    task test_sequential;
        imem_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c % 3 == 0) begin
                nCompared++; if (imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL seq_req c=%0d got %b want 1", c, imem_req); end
                nCompared++; if (imem_addr !== 32'(4 * (c / 3))) begin nMismatched++; $display("[TB] FAIL seq_addr c=%0d got %h want %h", c, imem_addr, 32'(4 * (c / 3))); end
                nCompared++; if (inst_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL seq_valid c=%0d got %b want 0", c, inst_valid); end
                imem_rvalid = 1'b0;
                commit = 1'b0;
            end else if (c % 3 == 1) begin
                nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL seq_wait_req c=%0d got %b want 0", c, imem_req); end
                nCompared++; if (inst_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL seq_valid c=%0d got %b want 0", c, inst_valid); end
                imem_rvalid = 1'b1;
                imem_rdata = ADDI;
            end else begin
                nCompared++; if (inst_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL seq_valid c=%0d got %b want 1", c, inst_valid); end
                nCompared++; if (inst !== ADDI) begin nMismatched++; $display("[TB] FAIL seq_inst c=%0d got %h want %h", c, inst, ADDI); end
                nCompared++; if (pc_plus4 !== 32'(4 * (c / 3) + 4)) begin nMismatched++; $display("[TB] FAIL seq_pc_plus4 c=%0d got %h want %h", c, pc_plus4, 32'(4 * (c / 3) + 4)); end
                imem_rvalid = 1'b0;
                commit = 1'b1;
            end
            tick;
        end
        commit = 1'b0;
        imem_ready = 1'b0;
        nCompared++; if (pc !== 32'hC) begin nMismatched++; $display("[TB] FAIL seq_end_pc got %h want %h", pc, 32'hC); end
    endtask

    task test_handshake;
        for (int i = 0; i < 4; i++) begin
            nCompared++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin nMismatched++; $display("[TB] FAIL hs_ready_wait i=%0d got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, 32'hC); end
            tick;
        end
        imem_ready = 1'b1;
        tick;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nCompared++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL hs_rvalid_wait i=%0d got req=%b valid=%b want 0 0", i, imem_req, inst_valid); end
            tick;
        end
        imem_rvalid = 1'b1;
        imem_rdata = ADDI;
        tick;
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nCompared++; if (inst !== ADDI || pc !== 32'hC || inst_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL hs_hold i=%0d got inst=%h pc=%h valid=%b want %h %h 1", i, inst, pc, inst_valid, ADDI, 32'hC); end
            imem_rvalid = (i == 2);
            imem_rdata = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
            tick;
        end
        imem_rvalid = 1'b0;
        nCompared++; if (inst !== ADDI) begin nMismatched++; $display("[TB] FAIL hs_spurious_rvalid got %h want %h", inst, ADDI); end
        commit = 1'b1;
        tick;
        nCompared++; if (pc !== 32'h10 || imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL hs_commit got pc=%h req=%b want %h 1", pc, imem_req, 32'h10); end
        tick;
        commit = 1'b0;
        nCompared++; if (pc !== 32'h10) begin nMismatched++; $display("[TB] FAIL hs_single_update got %h want %h", pc, 32'h10); end
    endtask

    task test_branches;
        fetchWord(JAL);  commitWith(32'h0, 32'h0, 32'h10);
        nCompared++; if (pc !== 32'h20) begin nMismatched++; $display("[TB] FAIL br_setup got %h want %h", pc, 32'h20); end
        fetchWord(BEQ);  commitWith(32'h5, 32'h5, 32'hFFFF_FFF8);
        nCompared++; if (pc !== 32'h18) begin nMismatched++; $display("[TB] FAIL beq_taken got %h want %h", pc, 32'h18); end
        fetchWord(JAL);  commitWith(32'h0, 32'h0, 32'h8);
        fetchWord(BNE);  commitWith(32'h5, 32'h5, 32'hFFFF_FFF8);
        nCompared++; if (pc !== 32'h24) begin nMismatched++; $display("[TB] FAIL bne_not_taken got %h want %h", pc, 32'h24); end
        fetchWord(BLT);  commitWith(32'hFFFF_FFFF, 32'h1, 32'h10);
        nCompared++; if (pc !== 32'h34) begin nMismatched++; $display("[TB] FAIL blt_taken got %h want %h", pc, 32'h34); end
        fetchWord(BLTU); commitWith(32'hFFFF_FFFF, 32'h1, 32'h10);
        nCompared++; if (pc !== 32'h38) begin nMismatched++; $display("[TB] FAIL bltu_not_taken got %h want %h", pc, 32'h38); end
        fetchWord(BGE);  commitWith(32'hFFFF_FFFF, 32'h1, 32'h10);
        nCompared++; if (pc !== 32'h3C) begin nMismatched++; $display("[TB] FAIL bge_not_taken got %h want %h", pc, 32'h3C); end
        fetchWord(BGEU); commitWith(32'hFFFF_FFFF, 32'h1, 32'h10);
        nCompared++; if (pc !== 32'h4C) begin nMismatched++; $display("[TB] FAIL bgeu_taken got %h want %h", pc, 32'h4C); end
        fetchWord(BR10); commitWith(32'h5, 32'h5, 32'h10);
        nCompared++; if (pc !== 32'h50) begin nMismatched++; $display("[TB] FAIL funct3_010_not_taken got %h want %h", pc, 32'h50); end
    endtask

    task test_jumps;
        fetchWord(JAL);  commitWith(32'h0, 32'h0, 32'hFFFF_FFF0);
        fetchWord(JAL);
        nCompared++; if (pc_plus4 !== 32'h44) begin nMismatched++; $display("[TB] FAIL jal_link got %h want %h", pc_plus4, 32'h44); end
        commitWith(32'h0, 32'h0, 32'h10);
        nCompared++; if (pc !== 32'h50) begin nMismatched++; $display("[TB] FAIL jal_target got %h want %h", pc, 32'h50); end
        fetchWord(JALR); commitWith(32'h1001, 32'h0, 32'h3);
        nCompared++; if (pc !== 32'h1004 || fetch_err !== 1'b0 || imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL jalr_aligned got pc=%h err=%b req=%b want %h 0 1", pc, fetch_err, imem_req, 32'h1004); end
    endtask

    task test_wrap;
        fetchWord(JALR); commitWith(32'hFFFF_FFF0, 32'h0, 32'hC);
        nCompared++; if (pc !== 32'hFFFF_FFFC) begin nMismatched++; $display("[TB] FAIL wrap_setup got %h want %h", pc, 32'hFFFF_FFFC); end
        fetchWord(ADDI);
        nCompared++; if (pc_plus4 !== 32'h0) begin nMismatched++; $display("[TB] FAIL wrap_pc_plus4 got %h want 0", pc_plus4); end
        commitWith(32'h0, 32'h0, 32'h0);
        nCompared++; if (pc !== 32'h0 || fetch_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_pc got pc=%h err=%b want 0 0", pc, fetch_err); end
    endtask

    task test_jalr_error;
        fetchWord(JALR); commitWith(32'h1001, 32'h0, 32'h2);
        nCompared++; if (pc !== 32'h1002) begin nMismatched++; $display("[TB] FAIL err_pc got %h want %h", pc, 32'h1002); end
        imem_ready = 1'b1;
        imem_rvalid = 1'b1;
        commit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nCompared++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h1002) begin nMismatched++; $display("[TB] FAIL err_sticky i=%0d got err=%b req=%b valid=%b pc=%h want 1 0 0 %h", i, fetch_err, imem_req, inst_valid, pc, 32'h1002); end
            tick;
        end
        imem_ready = 1'b0;
        imem_rvalid = 1'b0;
        commit = 1'b0;
    endtask

    task test_reset_mid_wait;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        fetchWord(JAL); commitWith(32'h0, 32'h0, 32'h80);
        imem_ready = 1'b1;
        tick;
        imem_ready = 1'b0;
        nCompared++; if (imem_req !== 1'b0 || pc !== 32'h80) begin nMismatched++; $display("[TB] FAIL rmw_in_wait got req=%b pc=%h want 0 %h", imem_req, pc, 32'h80); end
        imem_rvalid = 1'b1;
        imem_rdata = ADDI;
        rst = 1'b1;
        #1;
        nCompared++; if (pc !== 32'h0 || inst !== NOP || inst_valid !== 1'b0 || imem_req !== 1'b0 || fetch_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmw_async got pc=%h inst=%h valid=%b req=%b err=%b", pc, inst, inst_valid, imem_req, fetch_err); end
        tick;
        rst = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        #1;
        nCompared++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin nMismatched++; $display("[TB] FAIL rmw_restart got req=%b addr=%h want 1 0", imem_req, imem_addr); end
        fetchWord(ADDI);
        nCompared++; if (inst_valid !== 1'b1 || inst !== ADDI || pc !== 32'h0) begin nMismatched++; $display("[TB] FAIL rmw_refetch got valid=%b inst=%h pc=%h", inst_valid, inst, pc); end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_handshake;
        test_branches;
        test_jumps;
        test_wrap;
        test_jalr_error;
        test_reset_mid_wait;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
